// File: rtl/mdio_responder.sv
// mdio_responder: Clause-22 MDIO slave (PHY side) running in the sys0_clk domain.
//
// MDC and MDIO are oversampled through 2-flop synchronizers. Bits are sampled
// on synchronized MDC rising edges. The pad is driven only on falling edges.
// The responder holds eight 16-bit registers, and the local host can also
// write them.
//
// Ports
//   sys0_clk, sys0_rstn     : system clock, async active-low reset
//   mdio_mdc, mdd_i         : management clock and MDIO pad input (async)
//   mdd_o, mdd_oe           : MDIO pad output value / output enable
//   host_we/addr/wdata      : local register write port
//   wr_strobe/addr/data     : pulse + payload for each accepted MDIO write
//   frame_ok, frame_err     : one-cycle frame completion / error pulses
//   busy                    : FSM is not idle
module mdio_responder #(
    parameter logic [4:0]  PHY_ADDR = 5'd1,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic        sys0_clk,
    input  logic        sys0_rstn,
    input  logic        mdio_mdc,
    input  logic        mdd_i,
    output logic        mdd_o,
    output logic        mdd_oe,
    input  logic        host_we,
    input  logic [2:0]  host_addr,
    input  logic [15:0] host_wdata,
    output logic        wr_strobe,
    output logic [4:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        frame_ok,
    output logic        frame_err,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE, ST, OP, ADDR, TA, DATA, SKIP
    } state_t;

    localparam int unsigned TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    logic          mdc_m, mdc_s, mdc_d;
    logic          mdd_m, mdd_s;
    logic          rise, fall;
    state_t        state;
    logic [5:0]    pre_cnt;
    logic [5:0]    bit_cnt;
    logic [5:0]    bit_nxt;
    logic [1:0]    op;
    logic          op_wr;
    logic [3:0]    addr_sr;
    logic [4:0]    addr_nxt;
    logic [4:0]    regad;
    logic [14:0]   data_sr;
    logic [15:0]   data_nxt;
    logic [15:0]   rd_sr;
    logic          rd_active;
    logic [TW-1:0] tmo_cnt;
    logic [15:0]   regs [8];

    assign rise     = mdc_s & ~mdc_d;
    assign fall     = ~mdc_s & mdc_d;
    assign bit_nxt  = bit_cnt + 6'd1;
    assign op_wr    = (op == 2'b01);
    // The last five sampled address bits. They form PHYAD at r9 and REGAD at r14.
    assign addr_nxt = {addr_sr, mdd_s};
    assign data_nxt = {data_sr, mdd_s};
    assign busy     = (state != IDLE);

    always_ff @(posedge sys0_clk or negedge sys0_rstn) begin
        if (!sys0_rstn) begin
            mdc_m     <= 1'b0;
            mdc_s     <= 1'b0;
            mdc_d     <= 1'b0;
            mdd_m     <= 1'b0;
            mdd_s     <= 1'b0;
            state     <= IDLE;
            pre_cnt   <= '0;
            bit_cnt   <= '0;
            op        <= '0;
            addr_sr   <= '0;
            regad     <= '0;
            data_sr   <= '0;
            rd_sr     <= '0;
            rd_active <= 1'b0;
            tmo_cnt   <= '0;
            mdd_o     <= 1'b1;
            mdd_oe    <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            for (int unsigned i = 0; i < 8; i++) regs[i] <= '0;
        end else begin
            mdc_m <= mdio_mdc;
            mdc_s <= mdc_m;
            mdc_d <= mdc_s;
            mdd_m <= mdd_i;
            mdd_s <= mdd_m;

            wr_strobe <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;

            if (host_we) regs[host_addr] <= host_wdata;

            // Read turnaround and data are driven on falling MDC edges.
            if (fall && rd_active) begin
                if (bit_cnt == 6'd15) begin
                    mdd_oe <= 1'b1;
                    mdd_o  <= 1'b0;
                end else if (bit_cnt >= 6'd16 && bit_cnt <= 6'd31) begin
                    mdd_o <= rd_sr[15];
                    rd_sr <= {rd_sr[14:0], 1'b0};
                end else if (bit_cnt == 6'd32) begin
                    mdd_oe    <= 1'b0;
                    mdd_o     <= 1'b1;
                    rd_active <= 1'b0;
                end
            end

            if (rise) begin
                tmo_cnt <= '0;
                case (state)
                    IDLE: begin
                        if (mdd_s) begin
                            if (pre_cnt != 6'd32) pre_cnt <= pre_cnt + 6'd1;
                        end else begin
                            if (pre_cnt == 6'd32) begin
                                state   <= ST;
                                bit_cnt <= 6'd1;
                            end
                            pre_cnt <= '0;
                        end
                    end
                    ST: begin
                        bit_cnt <= bit_nxt;
                        if (mdd_s) begin
                            state <= OP;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                    OP: begin
                        bit_cnt <= bit_nxt;
                        if (bit_cnt == 6'd2) begin
                            op[1] <= mdd_s;
                        end else begin
                            op[0] <= mdd_s;
                            if (op[1] == mdd_s) begin
                                frame_err <= 1'b1;
                                state     <= IDLE;
                            end else begin
                                state <= ADDR;
                            end
                        end
                    end
                    ADDR: begin
                        bit_cnt <= bit_nxt;
                        addr_sr <= addr_nxt[3:0];
                        if (bit_nxt == 6'd9 && addr_nxt != PHY_ADDR) begin
                            state <= SKIP;
                        end else if (bit_nxt == 6'd14) begin
                            regad     <= addr_nxt;
                            // Read data is captured here so later host writes cannot tear the frame.
                            rd_sr     <= (addr_nxt[4:3] == 2'b00) ? regs[addr_nxt[2:0]] : 16'hFFFF;
                            rd_active <= ~op_wr;
                            state     <= TA;
                        end
                    end
                    TA: begin
                        bit_cnt <= bit_nxt;
                        // Write TA must be 1 then 0. Read TA is ignored because we drive it ourselves.
                        if (op_wr && (mdd_s != (bit_nxt == 6'd15))) begin
                            frame_err <= 1'b1;
                            state     <= SKIP;
                        end else if (bit_nxt == 6'd16) begin
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        bit_cnt <= bit_nxt;
                        data_sr <= data_nxt[14:0];
                        if (bit_nxt == 6'd32) begin
                            state    <= IDLE;
                            pre_cnt  <= '0;
                            frame_ok <= 1'b1;
                            if (op_wr) begin
                                if (regad[4:3] == 2'b00) regs[regad[2:0]] <= data_nxt;
                                wr_strobe <= 1'b1;
                                wr_addr   <= regad;
                                wr_data   <= data_nxt;
                            end
                        end
                    end
                    SKIP: begin
                        bit_cnt <= bit_nxt;
                        if (bit_nxt == 6'd32) begin
                            state   <= IDLE;
                            pre_cnt <= '0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                if (tmo_cnt == TMO_LAST) begin
                    tmo_cnt   <= '0;
                    state     <= IDLE;
                    pre_cnt   <= '0;
                    frame_err <= 1'b1;
                    rd_active <= 1'b0;
                    mdd_oe    <= 1'b0;
                    mdd_o     <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mdio_responder.sv
// tb_mdio_responder: directed bench for mdio_responder. A station-manager model
// drives MDC and MDIO and captures the resolved pad value at each MDC rise.
module tb_mdio_responder;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        mdc = 1'b0;
    logic        sta_o = 1'b1;
    logic        pad;
    logic        mdd_o, mdd_oe;
    logic        host_we = 1'b0;
    logic [2:0]  host_addr = '0;
    logic [15:0] host_wdata = '0;
    logic        wr_strobe;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic        frame_ok, frame_err, busy;

    int n_cmp = 0;
    int n_fail = 0;
    int ok_cnt = 0, err_cnt = 0, wstb_cnt = 0, err_bit = 0, cur_bit = 0;
    logic busy_seen = 1'b0;

    assign pad = mdd_oe ? mdd_o : sta_o;

    always #5 clk = ~clk;

    mdio_responder #(.PHY_ADDR(5'd1), .TIMEOUT(1024)) dut (
        .sys0_clk(clk), .sys0_rstn(rstn), .mdio_mdc(mdc), .mdd_i(pad),
        .mdd_o(mdd_o), .mdd_oe(mdd_oe), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
        .wr_data(wr_data), .frame_ok(frame_ok), .frame_err(frame_err), .busy(busy)
    );

    always @(negedge clk) begin
        if (frame_ok) ok_cnt++;
        if (wr_strobe) wstb_cnt++;
        if (frame_err) begin
            err_cnt++;
            err_bit = cur_bit;
        end
        if (busy) busy_seen = 1'b1;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic host_wr(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        host_we = 1'b1; host_addr = a; host_wdata = d;
        @(negedge clk);
        host_we = 1'b0;
    endtask

    task automatic mdc_bit(input logic b, output logic smp, output logic oe_smp);
        sta_o = b;
        #80;
        smp = pad;
        oe_smp = mdd_oe;
        mdc = 1'b1;
        #80;
        mdc = 1'b0;
    endtask

    // Sends a preamble and the first nbits of body. It optionally issues a host write before bit hw_at.
    task automatic frame(input int pre, input logic [31:0] body, input int nbits,
                         input int hw_at, input logic [2:0] hw_a, input logic [15:0] hw_d,
                         output logic [31:0] cap, output logic [31:0] oe_cap);
        logic s, o;
        cap = '0;
        oe_cap = '0;
        @(negedge clk);
        #2;
        cur_bit = 0;
        for (int i = 0; i < pre; i++) mdc_bit(1'b1, s, o);
        for (int i = 1; i <= nbits; i++) begin
            cur_bit = i;
            if (i == hw_at) host_wr(hw_a, hw_d);
            mdc_bit(body[32-i], s, o);
            cap[32-i] = s;
            oe_cap[32-i] = o;
        end
        sta_o = 1'b1;
    endtask

    function automatic logic [31:0] wr_body(input logic [4:0] phy, input logic [4:0] ra, input logic [15:0] d);
        return {2'b01, 2'b01, phy, ra, 2'b10, d};
    endfunction

    function automatic logic [31:0] rd_body(input logic [4:0] phy, input logic [4:0] ra);
        return {2'b01, 2'b10, phy, ra, 2'b11, 16'hFFFF};
    endfunction

    initial begin
        logic [31:0] cap, oec;
        int ok0, err0, ws0;
        bit got;

        // Reset state
        #23;
        chk("rst_oe", {31'd0, mdd_oe}, 32'd0);
        chk("rst_o", {31'd0, mdd_o}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_flags", {29'd0, wr_strobe, frame_ok, frame_err}, 32'd0);
        chk("rst_wr_addr", {27'd0, wr_addr}, 32'd0);
        chk("rst_wr_data", {16'd0, wr_data}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (5) @(negedge clk);

        // MDIO write reg3 = A5C3
        ok0 = ok_cnt; ws0 = wstb_cnt; err0 = err_cnt;
        frame(32, wr_body(5'd1, 5'd3, 16'hA5C3), 32, 0, 3'd0, 16'd0, cap, oec);
        #100;
        chk("wr3_strobe", wstb_cnt - ws0, 1);
        chk("wr3_ok", ok_cnt - ok0, 1);
        chk("wr3_err", err_cnt - err0, 0);
        chk("wr3_addr", {27'd0, wr_addr}, 32'd3);
        chk("wr3_data", {16'd0, wr_data}, 32'h0000A5C3);
        chk("wr3_oe", oec, 32'd0);

        // Read reg3 back
        ok0 = ok_cnt;
        frame(32, rd_body(5'd1, 5'd3), 32, 0, 3'd0, 16'd0, cap, oec);
        #100;
        chk("rd3_data", {16'd0, cap[15:0]}, 32'h0000A5C3);
        chk("rd3_ok", ok_cnt - ok0, 1);

        // Host write reg5, then read with TA/oe timing checks
        host_wr(3'd5, 16'h1234);
        frame(32, rd_body(5'd1, 5'd5), 32, 0, 3'd0, 16'd0, cap, oec);
        chk("rd5_oe_r15", {31'd0, oec[17]}, 32'd0);
        chk("rd5_oe_r16", {31'd0, oec[16]}, 32'd1);
        chk("rd5_ta_zero", {31'd0, cap[16]}, 32'd0);
        chk("rd5_oe_data", {16'd0, oec[15:0]}, 32'h0000FFFF);
        chk("rd5_data", {16'd0, cap[15:0]}, 32'h00001234);
        #100;
        chk("rd5_oe_end", {31'd0, mdd_oe}, 32'd0);

        // Read latched at r14: host write mid-frame must not alter it
        frame(32, rd_body(5'd1, 5'd5), 32, 20, 3'd5, 16'h5555, cap, oec);
        #100;
        chk("rd5_latched", {16'd0, cap[15:0]}, 32'h00001234);
        frame(32, rd_body(5'd1, 5'd5), 32, 0, 3'd0, 16'd0, cap, oec);
        #100;
        chk("rd5_new", {16'd0, cap[15:0]}, 32'h00005555);

        // Foreign PHY address: silent
        ok0 = ok_cnt; err0 = err_cnt;
        frame(32, rd_body(5'd2, 5'd3), 32, 0, 3'd0, 16'd0, cap, oec);
        #100;
        chk("phy2_oe", oec, 32'd0);
        chk("phy2_ok", ok_cnt - ok0, 0);
        chk("phy2_err", err_cnt - err0, 0);
        frame(32, rd_body(5'd1, 5'd3), 32, 0, 3'd0, 16'd0, cap, oec);
        #100;
        chk("phy1_after", {16'd0, cap[15:0]}, 32'h0000A5C3);

        // 31-bit preamble ignored, 32-bit accepted
        ok0 = ok_cnt; ws0 = wstb_cnt;
        busy_seen = 1'b0;
        frame(31, wr_body(5'd1, 5'd6, 16'h0F0F), 32, 0, 3'd0, 16'd0, cap, oec);
        #100;
        chk("pre31_busy", {31'd0, busy_seen}, 32'd0);
        chk("pre31_ok", ok_cnt - ok0, 0);
        chk("pre31_strobe", wstb_cnt - ws0, 0);
        frame(32, rd_body(5'd1, 5'd6), 32, 0, 3'd0, 16'd0, cap, oec);
        #100;
        chk("pre31_reg6", {16'd0, cap[15:0]}, 32'h00000000);
        frame(32, wr_body(5'd1, 5'd6, 16'h0F0F), 32, 0, 3'd0, 16'd0, cap, oec);
        #100;
        chk("pre32_addr", {27'd0, wr_addr}, 32'd6);
        chk("pre32_data", {16'd0, wr_data}, 32'h00000F0F);

        // OP=11 -> frame_err at r4, no change
        err0 = err_cnt; ws0 = wstb_cnt;
        frame(32, {2'b01, 2'b11, 5'd1, 5'd6, 2'b10, 16'hBEEF}, 32, 0, 3'd0, 16'd0, cap, oec);
        #100;
        chk("op11_err", err_cnt - err0, 1);
        chk("op11_bit", err_bit, 4);
        chk("op11_strobe", wstb_cnt - ws0, 0);

        // TA=00 -> frame_err, no strobe
        err0 = err_cnt; ws0 = wstb_cnt; ok0 = ok_cnt;
        frame(32, {2'b01, 2'b01, 5'd1, 5'd6, 2'b00, 16'hCAFE}, 32, 0, 3'd0, 16'd0, cap, oec);
        #100;
        chk("ta00_err", err_cnt - err0, 1);
        chk("ta00_bit", err_bit, 15);
        chk("ta00_strobe", wstb_cnt - ws0, 0);
        chk("ta00_ok", ok_cnt - ok0, 0);
        frame(32, rd_body(5'd1, 5'd6), 32, 0, 3'd0, 16'd0, cap, oec);
        #100;
        chk("reg6_kept", {16'd0, cap[15:0]}, 32'h00000F0F);

        // Unimplemented REGAD 20: strobe, reads FFFF
        ws0 = wstb_cnt;
        frame(32, wr_body(5'd1, 5'd20, 16'h1111), 32, 0, 3'd0, 16'd0, cap, oec);
        #100;
        chk("ra20_strobe", wstb_cnt - ws0, 1);
        chk("ra20_addr", {27'd0, wr_addr}, 32'd20);
        frame(32, rd_body(5'd1, 5'd20), 32, 0, 3'd0, 16'd0, cap, oec);
        #100;
        chk("ra20_read", {16'd0, cap[15:0]}, 32'h0000FFFF);

        // MDC stops after r20 of a read -> timeout
        err0 = err_cnt;
        frame(32, rd_body(5'd1, 5'd3), 20, 0, 3'd0, 16'd0, cap, oec);
        chk("tmo_driving", {31'd0, mdd_oe}, 32'd1);
        repeat (880) @(negedge clk);
        chk("tmo_early", err_cnt - err0, 0);
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (err_cnt != err0) got = 1'b1;
        end
        chk("tmo_err", err_cnt - err0, 1);
        repeat (2) @(negedge clk);
        chk("tmo_oe", {31'd0, mdd_oe}, 32'd0);
        chk("tmo_busy", {31'd0, busy}, 32'd0);

        // Reset mid-read at r25
        frame(32, rd_body(5'd1, 5'd3), 25, 0, 3'd0, 16'd0, cap, oec);
        chk("mrst_driving", {31'd0, mdd_oe}, 32'd1);
        #3;
        rstn = 1'b0;
        #1;
        chk("mrst_oe", {31'd0, mdd_oe}, 32'd0);
        chk("mrst_o", {31'd0, mdd_o}, 32'd1);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        frame(32, rd_body(5'd1, 5'd3), 32, 0, 3'd0, 16'd0, cap, oec);
        #100;
        chk("mrst_reg3", {16'd0, cap[15:0]}, 32'h00000000);
        chk("mrst_wr_addr", {27'd0, wr_addr}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
